// File: rtl/alu_sequencer.sv
// Control FSM for the bus-based datapath (R0-R7, A, ALU, G, shared BusWires).
// Latches an instruction from DIN and decodes state + IR into every bus
// source select, register load enable and ALU opcode.
module alu_sequencer #(
    parameter int IRW  = 9,
    parameter int NREG = 8
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            Run,
    input  logic [IRW-1:0]  DIN,
    output logic            IRin,
    output logic [IRW-1:0]  IR,
    output logic [NREG-1:0] Rin,
    output logic [NREG-1:0] Rout,
    output logic            Ain,
    output logic            Gin,
    output logic            Gout,
    output logic            DINout,
    output logic [3:0]      aluSignal,
    output logic            Done
);

    typedef enum logic [1:0] {
        T0,
        T1,
        T2,
        T3
    } state_t;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ALU_BASE = 3'b010;

    state_t         state_q, state_d;
    logic [IRW-1:0] ir_q, ir_d;

    logic [2:0] op;
    logic [2:0] rx;
    logic [2:0] ry;

    assign op = ir_q[8:6];
    assign rx = ir_q[5:3];
    assign ry = ir_q[2:0];
    assign IR = ir_q;

    function automatic logic [NREG-1:0] onehot(input logic [2:0] idx);
        logic [NREG-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // State and instruction register, synchronously reset to T0 / IR=0.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= T0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state and output decode from current state and IR.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        IRin      = 1'b0;
        Rin       = '0;
        Rout      = '0;
        Ain       = 1'b0;
        Gin       = 1'b0;
        Gout      = 1'b0;
        DINout    = 1'b0;
        aluSignal = 4'b0000;
        Done      = 1'b0;
        unique case (state_q)
            T0: begin
                // Reset has priority: no IR load is requested while it is held.
                IRin = Run & ~Reset;
                if (Run) begin
                    ir_d    = DIN;
                    state_d = T1;
                end
            end
            T1: begin
                Rin = onehot(rx);
                if (op == OP_MV) begin
                    Rout    = onehot(ry);
                    Done    = 1'b1;
                    state_d = T0;
                end else if (op == OP_MVI) begin
                    DINout  = 1'b1;
                    Done    = 1'b1;
                    state_d = T0;
                end else begin
                    Rin     = '0;
                    Rout    = onehot(rx);
                    Ain     = 1'b1;
                    state_d = T2;
                end
            end
            T2: begin
                Rout      = onehot(ry);
                Gin       = 1'b1;
                aluSignal = {1'b0, op - OP_ALU_BASE};
                state_d   = T3;
            end
            T3: begin
                Gout    = 1'b1;
                Rin     = onehot(rx);
                Done    = 1'b1;
                state_d = T0;
            end
            default: state_d = T0;
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: instruction-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_alu_sequencer;

    logic       Clock;
    logic       Reset;
    logic       Run;
    logic [8:0] DIN;
    logic       IRin;
    logic [8:0] IR;
    logic [7:0] Rin;
    logic [7:0] Rout;
    logic       Ain;
    logic       Gin;
    logic       Gout;
    logic       DINout;
    logic [3:0] aluSignal;
    logic       Done;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model: current instruction and cycle index within it
    // (0 = waiting in fetch, 1..len-1 = execution cycles).
    logic [8:0] m_ir;
    int         m_step;

    alu_sequencer #(.IRW(9), .NREG(8)) dut (
        .Clock(Clock), .Reset(Reset), .Run(Run), .DIN(DIN),
        .IRin(IRin), .IR(IR), .Rin(Rin), .Rout(Rout),
        .Ain(Ain), .Gin(Gin), .Gout(Gout), .DINout(DINout),
        .aluSignal(aluSignal), .Done(Done)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic int instr_len(input logic [8:0] ins);
        return (ins[8:6] < 3'd2) ? 2 : 4;
    endfunction

    // Drive inputs after the falling edge, then compare DUT outputs to the model.
    task automatic drive(input logic rst, input logic run, input logic [8:0] din);
        logic [2:0] op, x, y;
        logic       e_irin, e_ain, e_gin, e_gout, e_dinout, e_done;
        logic [7:0] e_rin, e_rout;
        logic [3:0] e_alu;
        int         nsrc;
        @(negedge Clock);
        Reset = rst;
        Run   = run;
        DIN   = din;
        #1;
        op = m_ir[8:6];
        x  = m_ir[5:3];
        y  = m_ir[2:0];
        e_irin = 0; e_ain = 0; e_gin = 0; e_gout = 0; e_dinout = 0; e_done = 0;
        e_rin = 0; e_rout = 0; e_alu = 0;
        if (m_step == 0) begin
            e_irin = run & ~rst;
        end else if (instr_len(m_ir) == 2) begin
            e_rin  = 8'(1) << x;
            e_done = 1;
            if (op == 3'd0) e_rout = 8'(1) << y;
            else            e_dinout = 1;
        end else if (m_step == 1) begin
            e_rout = 8'(1) << x;
            e_ain  = 1;
        end else if (m_step == 2) begin
            e_rout = 8'(1) << y;
            e_gin  = 1;
            e_alu  = 4'(int'(op) - 2);
        end else begin
            e_gout = 1;
            e_rin  = 8'(1) << x;
            e_done = 1;
        end
        chk("IRin", 16'(IRin), 16'(e_irin));
        chk("IR", 16'(IR), 16'(m_ir));
        chk("Rin", 16'(Rin), 16'(e_rin));
        chk("Rout", 16'(Rout), 16'(e_rout));
        chk("Ain", 16'(Ain), 16'(e_ain));
        chk("Gin", 16'(Gin), 16'(e_gin));
        chk("Gout", 16'(Gout), 16'(e_gout));
        chk("DINout", 16'(DINout), 16'(e_dinout));
        chk("aluSignal", 16'(aluSignal), 16'(e_alu));
        chk("Done", 16'(Done), 16'(e_done));
        nsrc = $countones(Rout) + int'(Gout) + int'(DINout);
        chk("bus_sources", 16'(nsrc), 16'((m_step == 0) ? 0 : 1));
    endtask

    // Advance one clock edge and step the model with the inputs just applied.
    task automatic adv();
        @(posedge Clock);
        if (Reset) begin
            m_step = 0;
            m_ir   = '0;
        end else if (m_step == 0) begin
            if (Run) begin
                m_ir   = DIN;
                m_step = 1;
            end
        end else begin
            m_step = (m_step + 1) % instr_len(m_ir);
        end
    endtask

    initial begin
        int n;
        int alu_seen;
        logic [8:0] ins;
        m_ir   = 'x;
        m_step = 0;
        Reset = 1; Run = 1; DIN = 9'h1FF;

        // 1. Reset held with Run=1: no IR load, everything zero.
        drive(1, 1, 9'h1FF); adv();
        m_ir = '0;
        drive(1, 1, 9'h1FF);
        chk("rst_IRin", 16'(IRin), 16'h0);
        adv();
        drive(0, 0, 9'h1FF);
        chk("rst_IR", 16'(IR), 16'h0);
        chk("rst_Done", 16'(Done), 16'h0);
        chk("rst_Rin", 16'(Rin), 16'h0);
        adv();

        // 2. mvi R2, immediate 0x0A5.
        drive(0, 1, 9'b001_010_000);
        chk("mvi_IRin", 16'(IRin), 16'h1);
        adv();
        drive(0, 0, 9'h0A5);
        chk("mvi_DINout", 16'(DINout), 16'h1);
        chk("mvi_Rin", 16'(Rin), 16'h04);
        chk("mvi_Done", 16'(Done), 16'h1);
        adv();
        drive(0, 0, 9'h000);
        chk("mvi_back_Done", 16'(Done), 16'h0);
        adv();

        // 3. sub R3,R5.
        drive(0, 1, 9'b011_011_101); adv();
        drive(0, 0, 9'h000);
        chk("sub_T1_Rout", 16'(Rout), 16'h08);
        chk("sub_T1_Ain", 16'(Ain), 16'h1);
        adv();
        drive(0, 0, 9'h000);
        chk("sub_T2_Rout", 16'(Rout), 16'h20);
        chk("sub_T2_Gin", 16'(Gin), 16'h1);
        chk("sub_T2_alu", 16'(aluSignal), 16'h1);
        adv();
        drive(0, 0, 9'h000);
        chk("sub_T3_Gout", 16'(Gout), 16'h1);
        chk("sub_T3_Rin", 16'(Rin), 16'h08);
        chk("sub_T3_Done", 16'(Done), 16'h1);
        adv();

        // 4. Sweep all opcodes with X=R0, Y=R7; measure cycle count incl. fetch.
        for (int op = 0; op < 8; op++) begin
            ins = {3'(op), 3'd0, 3'd7};
            drive(0, 1, ins); adv();
            n = 1;
            alu_seen = -1;
            for (int k = 0; k < 8; k++) begin
                drive(0, 0, 9'($urandom));
                n++;
                if (Gin) alu_seen = int'(aluSignal);
                if (Done) begin
                    adv();
                    break;
                end
                adv();
            end
            chk($sformatf("sweep_len_op%0d", op), 16'(n), 16'((op < 2) ? 2 : 4));
            if (op >= 2)
                chk($sformatf("sweep_alu_op%0d", op), 16'(alu_seen), 16'(op - 2));
        end
        chk("srl_code", 16'(alu_seen), 16'h5);

        // 5. Reset during T2 of add R1,R2: back in T0, no Rin and no Done after.
        drive(0, 1, 9'b010_001_010); adv();
        drive(0, 0, 9'h000); adv();
        drive(1, 0, 9'h000); adv();
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 9'h000);
            chk("rstmid_Rin", 16'(Rin), 16'h0);
            chk("rstmid_Done", 16'(Done), 16'h0);
            chk("rstmid_IR", 16'(IR), 16'h0);
            adv();
        end

        // 6. Run held high across add R1,R2 then mv R1,R4.
        drive(0, 1, 9'b010_001_010); adv();
        drive(0, 1, 9'b000_001_100);
        chk("hold_T1_IRin", 16'(IRin), 16'h0);
        adv();
        drive(0, 1, 9'b000_001_100);
        chk("hold_T2_IRin", 16'(IRin), 16'h0);
        adv();
        drive(0, 1, 9'b000_001_100);
        chk("hold_T3_IRin", 16'(IRin), 16'h0);
        chk("hold_T3_Done", 16'(Done), 16'h1);
        adv();
        drive(0, 1, 9'b000_001_100);
        chk("hold_next_IRin", 16'(IRin), 16'h1);
        chk("hold_next_Done", 16'(Done), 16'h0);
        adv();
        drive(0, 0, 9'h000);
        chk("mv_IR", 16'(IR), 16'b000_001_100);
        chk("mv_Rout", 16'(Rout), 16'h10);
        chk("mv_Rin", 16'(Rin), 16'h02);
        chk("mv_Done", 16'(Done), 16'h1);
        adv();

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 600; c++) begin
            drive(($urandom % 37) == 0, 1'($urandom), 9'($urandom));
            adv();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
